quad_step_decoder: RTL and testbench
====================================

// Module: quad_step_decoder
// PURPOSE
//   Quadrature (A/B) encoder front end: synchronises and glitch-filters two async
//   encoder phases, decodes x4 Gray transitions, emits one-cycle step commands
//   (step_en/step_dir) that directly drive the up/down counter's cnt_en/dir inputs.
//   Also flags and counts illegal double transitions.
// PARAMETERS
//   FILT_LEN   4   consecutive stable cycles before a filtered phase changes (>=1)
//   ERR_W      8   width of saturating error counter
// PORTS
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high reset
//   enc_a      in   1      encoder phase A, asynchronous
//   enc_b      in   1      encoder phase B, asynchronous
//   enc_en     in   1      1 = steps forwarded; 0 = steps suppressed, tracking continues
//   err_clr    in   1      synchronous clear of err_cnt
//   step_en    out  1      one-cycle pulse per legal transition (-> counter cnt_en)
//   step_dir   out  1      1 = forward/count up (A leads B), 0 = reverse (-> counter dir)
//   ab_filt    out  2      filtered {A,B}
//   err        out  1      one-cycle pulse on illegal transition
//   err_cnt    out  ERR_W  saturating illegal-transition count
// BEHAVIOUR
//   - Reset (reset=1 at clk edge): all outputs 0, sync flops 0, filter counters 0, FSM=INIT.
//   - Sync: 2-FF synchroniser per phase.
//   - Filter (per phase): counter increments while sync out != filtered value, else clears;
//     filtered value takes sync value when counter reaches FILT_LEN-1 and input still differs.
//     Pulse shorter than FILT_LEN cycles never reaches ab_filt.
//   - Latency: enc_x edge -> ab_filt change = FILT_LEN+2 cycles; -> step_en = FILT_LEN+3.
//   - FSM states: INIT, TRACK.
//     INIT: lasts FILT_LEN+2 cycles after reset; ab_filt follows sync output directly;
//     step_en=err=0. Then -> TRACK. Avoids spurious step/error from reset value 00.
//     TRACK: compare ab_filt (new) with registered previous value each cycle.
//   - Forward sequence 00->10->11->01->00 (A leads): step_dir=1. Reverse order: step_dir=0.
//     Each legal single-bit change -> step_en=1 for exactly one cycle (x4 decode).
//   - No change: step_en=0; step_dir holds last value.
//   - Both bits change same cycle: err=1 one cycle, step_en=0, step_dir unchanged,
//     previous value updated to new ab_filt (re-sync, no second error).
//   - enc_en=0: step_en forced 0; decode, err and err_cnt still active. Re-enabling
//     produces no step for transitions that occurred while disabled.
//   - err_cnt: +1 per err pulse, saturates at 2**ERR_W-1. err_clr and err in same cycle:
//     clear wins (result 0).
//   - Reset mid-operation: reset takes effect next edge regardless of state; returns to INIT.
// STRUCTURE
//   - quad_pkg: typedef enum logic {INIT, TRACK} qd_state_t; localparams FWD_NEXT[4] Gray
//     successor table; function for INIT cycle count (FILT_LEN+2).
//   - Sub-module quad_filter (2-FF sync + stability filter, param FILT_LEN), instantiated
//     once per phase; top holds FSM, decode, error counter.
// TESTING (FILT_LEN=4, ERR_W=8)
//   1. Reset with A=B=1 held: after 6 cycles ab_filt=11, no step_en, no err in any cycle.
//   2. Forward: drive 00->10->11->01->00, each held 10 cycles -> 4 step_en pulses,
//      step_dir=1, each 7 cycles after input edge; then reverse -> 4 pulses, step_dir=0.
//   3. Glitch: 3-cycle pulse on A -> ab_filt unchanged, no step_en; 4-cycle pulse -> 2 steps.
//   4. Illegal: 00->11 same cycle -> one err pulse, err_cnt=1, no step_en; 300 such
//      events -> err_cnt saturates at 255; err_clr with err -> err_cnt=0.
//   5. enc_en=0 during 3 forward transitions -> step_en stays 0; re-enable then 1 forward
//      transition -> exactly 1 step_en.
//   6. Assert reset mid-sequence -> next cycle all outputs 0, FSM INIT, no step after release.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
//   qd_state_t   : decoder FSM state (INIT while filters settle, TRACK afterwards)
//   FWD_NEXT     : forward (A leads B) Gray successor of each {A,B} code
//   init_cycles  : number of INIT cycles after reset for a given filter length
package quad_pkg;

  typedef enum logic {INIT, TRACK} qd_state_t;

  // Index = current {A,B}; value = next {A,B} when moving forward.
  // Forward order: 00 -> 10 -> 11 -> 01 -> 00.
  localparam logic [1:0] FWD_NEXT [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

  function automatic int unsigned init_cycles(input int unsigned filt_len);
    return filt_len + 2;
  endfunction

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    return FWD_NEXT[ab];
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder phase: 2-FF synchroniser followed by a stability filter.
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous phase input
//   bypass     : 1 = output loads the synchronised value directly (settling)
//   dout       : filtered phase (registered)
// The output only changes after the synchronised input has differed from it
// for FILT_LEN consecutive cycles.
module quad_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic bypass,
  output logic dout
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (bypass) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronise and filter A/B, decode x4 Gray
// transitions into one-cycle step commands, and flag/count illegal jumps.
//   clk, reset : clock, synchronous active-high reset
//   enc_a/b    : asynchronous encoder phases
//   enc_en     : 1 = forward steps; 0 = suppress steps (tracking continues)
//   err_clr    : synchronous clear of err_cnt (wins over a same-cycle error)
//   step_en    : one-cycle pulse per legal transition
//   step_dir   : 1 = forward (A leads B), holds between steps
//   ab_filt    : filtered {A,B}
//   err        : one-cycle pulse on a double-bit transition
//   err_cnt    : saturating count of err pulses
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_en,
  input  logic             err_clr,
  output logic             step_en,
  output logic             step_dir,
  output logic [1:0]       ab_filt,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned INIT_LEN = init_cycles(FILT_LEN);
  localparam int unsigned INIT_W   = $clog2(INIT_LEN);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

  qd_state_t         state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]        prev_q, prev_d;
  logic              step_en_q, step_en_d;
  logic              step_dir_q, step_dir_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              filt_a, filt_b;
  logic              bypass;
  logic [1:0]        ab_cur;

  // While settling, the filters copy the synchroniser output so ab_filt
  // reflects the real encoder position before decoding starts.
  assign bypass = (state_q == INIT);

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk    (clk),
    .reset  (reset),
    .din    (enc_a),
    .bypass (bypass),
    .dout   (filt_a)
  );

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk    (clk),
    .reset  (reset),
    .din    (enc_b),
    .bypass (bypass),
    .dout   (filt_b)
  );

  assign ab_cur = {filt_a, filt_b};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = ab_cur;
    step_en_d  = 1'b0;
    step_dir_d = step_dir_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = TRACK;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      TRACK: begin
        if (ab_cur != prev_q) begin
          if (ab_cur == fwd_next(prev_q)) begin
            step_en_d  = enc_en;
            step_dir_d = 1'b1;
          end else if (prev_q == fwd_next(ab_cur)) begin
            step_en_d  = enc_en;
            step_dir_d = 1'b0;
          end else begin
            // Both bits moved: flag it; prev_d re-syncs to the new code.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      prev_q     <= '0;
      step_en_q  <= 1'b0;
      step_dir_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_en_q  <= step_en_d;
      step_dir_q <= step_dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign step_en  = step_en_q;
  assign step_dir = step_dir_q;
  assign ab_filt  = ab_cur;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;
  import quad_pkg::*;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic       enc_en;
  logic       err_clr;
  logic       step_en;
  logic       step_dir;
  logic [1:0] ab_filt;
  logic       err;
  logic [7:0] err_cnt;

  quad_step_decoder #(.FILT_LEN(4), .ERR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_en   (enc_en),
    .err_clr  (err_clr),
    .step_en  (step_en),
    .step_dir (step_dir),
    .ab_filt  (ab_filt),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned step_seen = 0;
  int unsigned err_seen  = 0;

  always @(negedge clk) begin
    if (step_en) step_seen <= step_seen + 1;
    if (err)     err_seen  <= err_seen + 1;
  end

  typedef struct {
    logic        a;
    logic        b;
    logic        en;
    int unsigned exp_steps;
    logic        chk_dir;
    logic        exp_dir;
    logic [1:0]  exp_ab;
    int unsigned exp_errs;
    int unsigned exp_err_cnt;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic a, input logic b, input logic en,
                              input int unsigned steps, input logic chk_dir,
                              input logic dir, input int unsigned errs,
                              input int unsigned ecnt);
    vec_t v;
    v.a = a; v.b = b; v.en = en; v.exp_steps = steps; v.chk_dir = chk_dir;
    v.exp_dir = dir; v.exp_ab = {a, b}; v.exp_errs = errs; v.exp_err_cnt = ecnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step_en"},  32'(step_en),  0);
    check({tag, "_step_dir"}, 32'(step_dir), 0);
    check({tag, "_ab_filt"},  32'(ab_filt),  0);
    check({tag, "_err"},      32'(err),      0);
    check({tag, "_err_cnt"},  32'(err_cnt),  0);
  endtask

  int unsigned s0, e0;

  initial begin
    // Table: starts from filtered 11 after reset with A=B=1.
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0, 0); // 11->01 fwd
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 0, 0); // 01->00 fwd
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 0, 0); // 00->10 fwd
    vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0, 0); // 10->11 fwd
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 0); // 11->10 rev
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 0); // 10->00 rev
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 0, 0); // 00->01 rev
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 0, 0); // 01->11 rev
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0); // disabled fwd
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0); // disabled fwd
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0); // disabled fwd
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0, 0); // re-enabled fwd
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 1); // 11->00 illegal
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1, 2); // 00->11 illegal

    // Reset with A=B=1 held.
    reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_en = 1'b1; err_clr = 1'b0;
    ticks(3);
    check_all_zero("reset");
    check("reset_state_init", 32'(dut.state_q == INIT), 1);
    reset = 1'b0;
    s0 = step_seen; e0 = err_seen;
    ticks(6);
    check("init_ab_filt", 32'(ab_filt), 3);
    ticks(4);
    check("init_no_step", step_seen - s0, 0);
    check("init_no_err",  err_seen - e0, 0);

    // Table-driven transitions.
    for (int unsigned i = 0; i < 14; i++) begin
      enc_a = vecs[i].a; enc_b = vecs[i].b; enc_en = vecs[i].en;
      s0 = step_seen; e0 = err_seen;
      ticks(10);
      check($sformatf("v%0d_steps", i),   step_seen - s0, vecs[i].exp_steps);
      check($sformatf("v%0d_ab_filt", i), 32'(ab_filt), 32'(vecs[i].exp_ab));
      check($sformatf("v%0d_errs", i),    err_seen - e0, vecs[i].exp_errs);
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), vecs[i].exp_err_cnt);
      if (vecs[i].chk_dir)
        check($sformatf("v%0d_step_dir", i), 32'(step_dir), 32'(vecs[i].exp_dir));
    end

    // Exact latency: 11 -> 01 forward.
    enc_a = 1'b0;
    ticks(5);
    check("lat_ab_before", 32'(ab_filt), 3);
    tick();
    check("lat_ab_at6", 32'(ab_filt), 1);
    check("lat_step_at6", 32'(step_en), 0);
    tick();
    check("lat_step_at7", 32'(step_en), 1);
    check("lat_dir_at7", 32'(step_dir), 1);
    tick();
    check("lat_step_at8", 32'(step_en), 0);
    ticks(4);

    // Glitches on A from 01: 3 cycles filtered out, 4 cycles passes.
    s0 = step_seen;
    enc_a = 1'b1; ticks(3); enc_a = 1'b0;
    ticks(12);
    check("glitch3_ab", 32'(ab_filt), 1);
    check("glitch3_steps", step_seen - s0, 0);
    s0 = step_seen;
    enc_a = 1'b1; ticks(4); enc_a = 1'b0;
    ticks(14);
    check("glitch4_ab", 32'(ab_filt), 1);
    check("glitch4_steps", step_seen - s0, 2);

    // 300 illegal 01<->10 jumps: counter saturates.
    s0 = step_seen; e0 = err_seen;
    for (int unsigned i = 0; i < 300; i++) begin
      enc_a = ~enc_a; enc_b = ~enc_b;
      ticks(10);
    end
    check("sat_errs", err_seen - e0, 300);
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_no_step", step_seen - s0, 0);
    check("sat_ab", 32'(ab_filt), 1);

    // err_clr in the same cycle as an err pulse: clear wins.
    enc_a = 1'b1; enc_b = 1'b0;
    ticks(6);
    check("clr_err_before", 32'(err), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err_pulse", 32'(err), 1);
    check("clr_err_cnt", 32'(err_cnt), 0);
    ticks(5);
    enc_a = 1'b0; enc_b = 1'b1;
    ticks(10);
    check("after_clr_err_cnt", 32'(err_cnt), 1);

    // Reset in the middle of a forward transition 01 -> 00.
    enc_b = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    check("midrst_state_init", 32'(dut.state_q == INIT), 1);
    tick();
    reset = 1'b0;
    s0 = step_seen; e0 = err_seen;
    ticks(14);
    check("midrst_no_step", step_seen - s0, 0);
    check("midrst_no_err", err_seen - e0, 0);
    check("midrst_ab", 32'(ab_filt), 0);
    check("midrst_dir", 32'(step_dir), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
